z3_cycle_ctrl: RTL and testbench

Zorro III slave bus-cycle sequencer for the A4092 CPLD.
- Synchronises FCS_n and decodes each cycle as autoconfig space, configured SCSI space, or not-ours.
- Drives SLAVE_n, DTACK_n and the data buffer enable, and hands the cycle to the autoconfig block (autoconfig_cycle/dtack) or the SCSI chip interface (scsi_req/scsi_ack).
- Optionally terminates hung cycles with BERR_n.

---
 rtl/z3_pkg.sv | 17 +
 rtl/z3_cycle_ctrl_sync2.sv | 21 ++
 rtl/z3_cycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_z3_cycle_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/z3_pkg.sv
// Shared types and constants for the Zorro III slave cycle sequencer.
package z3_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DECODE   = 3'd1,
      AC       = 3'd2,
      SCSI     = 3'd3,
      ACK      = 3'd4,
      ERR      = 3'd5,
      WAIT_END = 3'd6
   } state_t;

   localparam logic [7:0] AC_BASE_DEF = 8'hFF;
   localparam int         TMO_W       = 8;

endpackage

// File: rtl/z3_cycle_ctrl_sync2.sv
// Two-flop synchroniser, clears to 0 on reset.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/z3_cycle_ctrl.sv
// Zorro III slave bus-cycle sequencer (autoconfig / SCSI space).
// Define Z3_TIMEOUT_EN to terminate hung cycles with BERR_n.
import z3_pkg::*;

module z3_cycle_ctrl #(
   parameter int         TIMEOUT_CYCLES = 64,
   parameter logic [7:0] AC_BASE        = AC_BASE_DEF
) (
   input  logic       CLK,
   input  logic       RESET_n,
   input  logic       FCS_n,
   input  logic       READ,
   input  logic [7:0] ADDR,
   input  logic       CFGIN_n,
   input  logic       configured,
   input  logic [7:0] scsi_base_addr,
   input  logic       ac_dtack,
   input  logic       scsi_ack,
   output logic       autoconfig_cycle,
   output logic       scsi_req,
   output logic       SLAVE_n,
   output logic       DTACK_n,
   output logic       BERR_n,
   output logic       buf_oe_n,
   output logic       buf_dir
);

   logic   fcs_raw;
   logic   fcs;
   logic   tmo;
   state_t state;
   state_t state_d;

   assign fcs_raw = ~FCS_n;

   sync2 u_sync (
      .clk   (CLK),
      .rst_n (RESET_n),
      .d     (fcs_raw),
      .q     (fcs)
   );

`ifdef Z3_TIMEOUT_EN
   logic [TMO_W-1:0] cnt;

   // DECODE always precedes AC/SCSI, so clearing there means cnt=0 on entry
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         cnt <= '0;
      end else if (state == DECODE) begin
         cnt <= '0;
      end else if (state == AC || state == SCSI) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tmo = (cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_tmo;

   assign unused_tmo = 32'(TIMEOUT_CYCLES);
   assign tmo        = 1'b0;
`endif

   always_comb begin
      state_d = state;
      if (state != IDLE && !fcs) begin
         state_d = IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (fcs) state_d = DECODE;
            DECODE:
               if (ADDR == AC_BASE && !CFGIN_n && !configured)
                  state_d = AC;
               else if (configured && ADDR == scsi_base_addr)
                  state_d = SCSI;
               else
                  state_d = WAIT_END;
            AC:
               if (ac_dtack)  state_d = ACK;
               else if (tmo)  state_d = ERR;
            SCSI:
               if (scsi_ack)  state_d = ACK;
               else if (tmo)  state_d = ERR;
            default: ;
         endcase
      end
   end

   logic acc_d, req_d, slave_d, dtack_d, berr_d, oe_d, dir_d;

   // outputs are a registered decode of the next state
   always_comb begin
      acc_d   = 1'b0;
      req_d   = 1'b0;
      slave_d = 1'b1;
      dtack_d = 1'b1;
      berr_d  = 1'b1;
      oe_d    = 1'b1;
      dir_d   = 1'b0;
      unique case (state_d)
         AC: begin
            acc_d   = 1'b1;
            slave_d = 1'b0;
            oe_d    = 1'b0;
            dir_d   = READ;
         end
         SCSI: begin
            req_d   = 1'b1;
            slave_d = 1'b0;
            oe_d    = 1'b0;
            dir_d   = READ;
         end
         ACK: begin
            slave_d = 1'b0;
            dtack_d = 1'b0;
            oe_d    = 1'b0;
            dir_d   = buf_dir;
         end
         ERR: begin
            slave_d = 1'b0;
            berr_d  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state            <= IDLE;
         autoconfig_cycle <= 1'b0;
         scsi_req         <= 1'b0;
         SLAVE_n          <= 1'b1;
         DTACK_n          <= 1'b1;
         BERR_n           <= 1'b1;
         buf_oe_n         <= 1'b1;
         buf_dir          <= 1'b0;
      end else begin
         state            <= state_d;
         autoconfig_cycle <= acc_d;
         scsi_req         <= req_d;
         SLAVE_n          <= slave_d;
         DTACK_n          <= dtack_d;
         BERR_n           <= berr_d;
         buf_oe_n         <= oe_d;
         buf_dir          <= dir_d;
      end
   end

endmodule

// File: tb/tb_z3_cycle_ctrl.sv
// Bench for z3_cycle_ctrl: directed vector table, random cycles, reset corner.
module tb_z3_cycle_ctrl;

   localparam int INF = 1 << 30;
`ifdef Z3_TIMEOUT_EN
   // TIMEOUT_CYCLES=8: AC/SCSI entered on edge 4, ERR taken on edge 4+8
   localparam int TERR = 12;
`else
   localparam int TERR = INF;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fcs_n = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] addr = 8'h00;
   logic       cfgin_n = 1'b1;
   logic       configured = 1'b0;
   logic [7:0] base = 8'h00;
   logic       ac_dtack = 1'b0;
   logic       scsi_ack = 1'b0;
   logic       acc, req, slave_n, dtack_n, berr_n, oe_n, dir;

   int errs = 0;
   int checks = 0;

   z3_cycle_ctrl #(.TIMEOUT_CYCLES(8), .AC_BASE(8'hFF)) dut (
      .CLK              (clk),
      .RESET_n          (rst_n),
      .FCS_n            (fcs_n),
      .READ             (rd),
      .ADDR             (addr),
      .CFGIN_n          (cfgin_n),
      .configured       (configured),
      .scsi_base_addr   (base),
      .ac_dtack         (ac_dtack),
      .scsi_ack         (scsi_ack),
      .autoconfig_cycle (acc),
      .scsi_req         (req),
      .SLAVE_n          (slave_n),
      .DTACK_n          (dtack_n),
      .BERR_n           (berr_n),
      .buf_oe_n         (oe_n),
      .buf_dir          (dir)
   );

   always #5 clk = ~clk;

   // kind: 0 = not ours, 1 = autoconfig, 2 = SCSI
   typedef struct {
      logic [7:0] addr;
      logic       cfgin_n;
      logic       configured;
      logic [7:0] base;
      logic       rd;
      int         ack_at;
      int         rise_at;
      int         kind;
   } vec_t;

   localparam logic [6:0] IDLE_OUT = 7'b0011110;

   function automatic int ref_kind(input vec_t v);
      if (v.addr == 8'hFF && !v.cfgin_n && !v.configured) return 1;
      if (v.configured && v.addr == v.base) return 2;
      return 0;
   endfunction

   task automatic check(input string name, input logic [6:0] exp);
      logic [6:0] got;
      got = {acc, req, slave_n, dtack_n, berr_n, oe_n, dir};
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%b exp=%b (acc req slv dtk berr oe dir)",
                  name, got, exp);
      end
   endtask

   // Edge e counts posedges after FCS_n fall; ack rises before edge ack_at,
   // FCS_n rises before edge rise_at; released at rise_at+2.
   task automatic run_txn(input vec_t v, input int gap, input string tag);
      int end_e, a_eff, ack_e, err_e;
      bit act;
      logic [6:0] exp;
      end_e = v.rise_at + 2;
      a_eff = (v.ack_at < 5) ? 5 : v.ack_at;
      ack_e = INF;
      if (v.ack_at != 0 && v.kind != 0 && a_eff < end_e && a_eff <= TERR)
         ack_e = a_eff;
      err_e = INF;
      if (v.kind != 0 && TERR < ack_e && TERR < end_e)
         err_e = TERR;
      for (int e = 1; e <= end_e + gap; e++) begin
         @(negedge clk);
         if (e == 1) begin
            addr = v.addr; cfgin_n = v.cfgin_n; configured = v.configured;
            base = v.base; rd = v.rd; fcs_n = 1'b0;
            ac_dtack = 1'b0; scsi_ack = 1'b0;
         end
         if (e == v.ack_at) begin
            ac_dtack = 1'b1; scsi_ack = 1'b1;
         end
         if (e == v.rise_at) fcs_n = 1'b1;
         @(posedge clk);
         #1;
         act = (v.kind != 0) && e >= 4 && e < end_e;
         exp[6] = act && v.kind == 1 && e < ack_e && e < err_e;
         exp[5] = act && v.kind == 2 && e < ack_e && e < err_e;
         exp[4] = !act;
         exp[3] = !(act && e >= ack_e);
         exp[2] = !(act && e >= err_e);
         exp[1] = !(act && e < err_e);
         exp[0] = act && e < err_e && v.rd;
         check($sformatf("%s e%0d", tag, e), exp);
      end
      ac_dtack = 1'b0;
      scsi_ack = 1'b0;
   endtask

   vec_t tbl [11];
   vec_t rv;

   initial begin
      tbl[0]  = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1,  6,   10, 1};
      tbl[1]  = '{8'h40, 1'b1, 1'b1, 8'h40, 1'b0,  9,   12, 2};
      tbl[2]  = '{8'h41, 1'b1, 1'b1, 8'h40, 1'b0,  6,    9, 0};
      tbl[3]  = '{8'hFF, 1'b1, 1'b0, 8'h40, 1'b1,  6,    9, 0};
      tbl[4]  = '{8'hFF, 1'b0, 1'b1, 8'h40, 1'b1,  6,    9, 0};
      tbl[5]  = '{8'h40, 1'b1, 1'b1, 8'h40, 1'b1,  0,    7, 2};
      tbl[6]  = '{8'h40, 1'b1, 1'b1, 8'h40, 1'b1,  0, 1000, 2};
      tbl[7]  = '{8'hFF, 1'b0, 1'b0, 8'h40, 1'b0,  3,    8, 1};
      tbl[8]  = '{8'h40, 1'b1, 1'b1, 8'h40, 1'b1, 12,   16, 2};
      tbl[9]  = '{8'h40, 1'b1, 1'b1, 8'h40, 1'b0, 14,   18, 2};
      tbl[10] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1,  7,   10, 2};

      #12;
      check("reset", IDLE_OUT);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_reset_idle%0d", i), IDLE_OUT);
      end

      // reset asserted while DTACK_n is low
      @(negedge clk);
      addr = 8'hFF; cfgin_n = 1'b0; configured = 1'b0; rd = 1'b1;
      fcs_n = 1'b0; ac_dtack = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("mid_ack_dtack", 7'b0000101);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_ack_reset", IDLE_OUT);
      fcs_n = 1'b1;
      ac_dtack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("mid_ack_idle%0d", i), IDLE_OUT);
      end

      for (int i = 0; i < 11; i++)
         run_txn(tbl[i], 1, $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         rv.configured = 1'($urandom_range(0, 1));
         rv.cfgin_n    = 1'($urandom_range(0, 1));
         rv.rd         = 1'($urandom_range(0, 1));
         rv.base       = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       rv.addr = 8'hFF;
            1:       rv.addr = rv.base;
            2:       rv.addr = rv.base ^ 8'h01;
            default: rv.addr = 8'($urandom);
         endcase
         rv.ack_at  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 14));
         rv.rise_at = int'($urandom_range(5, 20));
         rv.kind    = ref_kind(rv);
         run_txn(rv, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
